// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane word RAM with registered read-first output,
// plus an optional MMIO block (counter, compare, match flag) enabled by DMEM_MMIO_EN.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  wr_en,
  output logic [31:0] dout,
  output logic        irq
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // No valid/ready: one access (read every cycle, write when any wr_en lane is set)
  // is accepted unconditionally on every rising edge.
  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  sel_mmio;
  logic [31:0]           ram_rdata;
  logic [31:0]           mmio_rdata;
  logic [31:0]           dout_d, dout_q;
  logic                  unused_addr;

  assign word_idx    = addr[ADDR_WIDTH+1:2];
  assign sel_mmio    = addr[31];
  assign ram_rdata   = mem[word_idx];
  assign unused_addr = ^{addr[30:ADDR_WIDTH+2], addr[1:0]};

  // RAM is not reset; a write in the reset cycle still lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!sel_mmio && wr_en[i]) begin
        mem[word_idx][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  always_comb begin
    dout_d = ram_rdata;
    if (sel_mmio) begin
      dout_d = mmio_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef DMEM_MMIO_EN
  logic [31:0] cnt_d, cnt_q;
  logic [31:0] cmp_d, cmp_q;
  logic        match_d, match_q;
  logic        mmio_wr;
  logic        clear_req;

  assign mmio_wr   = sel_mmio && (wr_en != 4'b0000);
  assign clear_req = mmio_wr && (addr[3:2] == 2'd2) && wr_en[0] && din[0];

  always_comb begin
    mmio_rdata = '0;
    case (addr[3:2])
      2'd0:    mmio_rdata = cnt_q;
      2'd1:    mmio_rdata = cmp_q;
      2'd2:    mmio_rdata = {31'd0, match_q};
      default: mmio_rdata = '0;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    cmp_d   = cmp_q;
    match_d = match_q;
    if (mmio_wr && (addr[3:2] == 2'd1)) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i]) begin
          cmp_d[8*i +: 8] = din[8*i +: 8];
        end
      end
    end
    // A match in the same cycle as a clear request wins.
    if (cnt_q == cmp_q) begin
      match_d = 1'b1;
    end else if (clear_req) begin
      match_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  assign irq = match_q;
`else
  assign mmio_rdata = '0;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM vector table, then MMIO sequences
// (DMEM_MMIO_EN builds) or MMIO-absent checks (default build).
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  wr_en;
  logic [31:0] dout;
  logic        irq;

  int checks;
  int errors;
  logic [31:0] cnt_m;
  logic [31:0] cnt_prev;

  dmem_responder #(.ADDR_WIDTH(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .din   (din),
    .wr_en (wr_en),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic r, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] w, input logic chk, input logic [31:0] exp);
    vec_t v;
    v.r = r; v.a = a; v.d = d; v.w = w; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  // One clock cycle; cnt_prev is the counter value during the cycle just run.
  task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    rst = r; addr = a; din = d; wr_en = w;
    @(posedge clk);
    #1;
    cnt_prev = cnt_m;
    cnt_m = r ? 32'd0 : cnt_m + 32'd1;
    rst = 1'b0; wr_en = 4'b0000;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] c;
    checks = 0; errors = 0; cnt_m = '0; cnt_prev = '0;
    rst = 1'b1; addr = '0; din = '0; wr_en = 4'b0000;

    vecs[0]  = mk(1'b1, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h0000_0000);
    vecs[1]  = mk(1'b0, 32'h0000_0010, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 32'h0000_0010, 32'hAAAA_AAAA, 4'b0100, 1'b1, 32'h1122_3344);
    vecs[3]  = mk(1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'h11AA_3344);
    vecs[4]  = mk(1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    vecs[5]  = mk(1'b0, 32'h0000_0020, 32'h0123_4567, 4'hF, 1'b1, 32'hDEAD_BEEF);
    vecs[6]  = mk(1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 32'h0123_4567);
    vecs[7]  = mk(1'b0, 32'h0000_0004, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0);
    vecs[8]  = mk(1'b0, 32'h0000_1004, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D);
    vecs[9]  = mk(1'b0, 32'h0000_0023, 32'hFFFF_FF99, 4'b0001, 1'b1, 32'h0123_4567);
    vecs[10] = mk(1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 32'h0123_4599);
    vecs[11] = mk(1'b0, 32'h7FFF_F004, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D);
    vecs[12] = mk(1'b0, 32'h0000_0040, 32'h1111_1111, 4'hF, 1'b0, 32'h0);
    vecs[13] = mk(1'b0, 32'h0000_0044, 32'h2222_2222, 4'hF, 1'b0, 32'h0);
    vecs[14] = mk(1'b0, 32'h0000_0040, 32'h0,         4'h0, 1'b1, 32'h1111_1111);
    vecs[15] = mk(1'b0, 32'h0000_0044, 32'h0,         4'h0, 1'b1, 32'h2222_2222);
    vecs[16] = mk(1'b0, 32'h0000_0FFC, 32'hA5A5_5A5A, 4'hF, 1'b0, 32'h0);
    vecs[17] = mk(1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 1'b1, 32'hA5A5_5A5A);

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].w);
      if (vecs[i].chk) check($sformatf("vec%0d_dout", i), dout, vecs[i].exp);
      if (i == 0) check("reset_irq", {31'd0, irq}, 32'd0);
    end

`ifdef DMEM_MMIO_EN
    // Reset-cycle MMIO write is discarded.
    cyc(1'b1, 32'h8000_0004, 32'h0000_0005, 4'hF);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_dout", dout, 32'd0);
    // CNT==CMP==0 in the first cycle after reset, so MATCH sets there.
    cyc(1'b0, 32'h8000_0004, 32'h0000_000A, 4'hF);
    check("cmp_after_rst_write", dout, 32'd0);
    check("match_at_zero", {31'd0, irq}, 32'd1);
    cyc(1'b0, 32'h8000_0008, 32'h0000_0001, 4'b0001);
    check("stat_read", dout, 32'd1);
    check("w1c_clears", {31'd0, irq}, 32'd0);
    cyc(1'b0, 32'h8000_0004, 32'h0, 4'h0);
    check("cmp_read", dout, 32'h0000_000A);
    cyc(1'b0, 32'h8000_0004, 32'hFFFF_FF0C, 4'b0001);
    cyc(1'b0, 32'hFFFF_FFF4, 32'h0, 4'h0);
    check("cmp_lane_write", dout, 32'h0000_000C);
    while (cnt_m != 32'd12) begin
      cyc(1'b0, 32'h8000_0008, 32'h0, 4'h0);
      check("irq_before_match", {31'd0, irq}, 32'd0);
    end
    cyc(1'b0, 32'h8000_0008, 32'h0, 4'h0);
    check("stat_in_match_cycle", dout, 32'd0);
    check("irq_rises", {31'd0, irq}, 32'd1);
    c = cnt_m;
    cyc(1'b0, 32'h8000_0000, 32'h0, 4'hF);
    check("cnt_read", dout, c);
    cyc(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    check("cnt_write_ignored", dout, c + 32'd1);
    cyc(1'b0, 32'h8000_000C, 32'hFFFF_FFFF, 4'hF);
    cyc(1'b0, 32'h8000_000C, 32'h0, 4'h0);
    check("off3_reads_zero", dout, 32'd0);
    cyc(1'b0, 32'h8000_0008, 32'h0000_0000, 4'b0001);
    check("w1c_zero_no_clear", {31'd0, irq}, 32'd1);
    cyc(1'b0, 32'h8000_0008, 32'hFFFF_FFFF, 4'b1110);
    check("w1c_lane_no_clear", {31'd0, irq}, 32'd1);
    cyc(1'b0, 32'h8000_0008, 32'h0000_0001, 4'b0001);
    check("w1c_clear2", {31'd0, irq}, 32'd0);
    cyc(1'b0, 32'h0000_0100, 32'h5A5A_1234, 4'hF);
    // Collision: W1C lands in the cycle CNT reaches CMP.
    cyc(1'b0, 32'h8000_0004, cnt_m + 32'd3, 4'hF);
    cyc(1'b0, 32'h8000_0008, 32'h0, 4'h0);
    cyc(1'b0, 32'h8000_0008, 32'h0, 4'h0);
    check("irq_before_collision", {31'd0, irq}, 32'd0);
    cyc(1'b0, 32'h8000_0008, 32'h0000_0001, 4'b0001);
    check("collision_set_wins", {31'd0, irq}, 32'd1);
    cyc(1'b0, 32'h8000_0008, 32'h0, 4'h0);
    check("collision_stat", dout, 32'd1);
    while (cnt_m != 32'h0000_1234) cyc(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    check("irq_before_reset", {31'd0, irq}, 32'd1);
    cyc(1'b1, 32'h0000_0104, 32'h0000_0077, 4'hF);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_dout", dout, 32'd0);
    cyc(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    check("midrst_cnt", dout, 32'd0);
    cyc(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    check("ram_kept", dout, 32'h5A5A_1234);
    cyc(1'b0, 32'h0000_0104, 32'h0, 4'h0);
    check("ram_write_in_rst", dout, 32'h0000_0077);
`else
    cyc(1'b0, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF);
    check("nommio_irq_w", {31'd0, irq}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 32'h8000_0000 | (k << 2), 32'h0, 4'h0);
      check($sformatf("nommio_dout%0d", k), dout, 32'd0);
      check($sformatf("nommio_irq%0d", k), {31'd0, irq}, 32'd0);
    end
    cyc(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    check("nommio_ram_untouched", dout, 32'hCAFE_F00D);
    cyc(1'b1, 32'h0000_0108, 32'h0000_0066, 4'hF);
    check("nommio_rst_dout", dout, 32'd0);
    cyc(1'b0, 32'h0000_0108, 32'h0, 4'h0);
    check("nommio_ram_write_in_rst", dout, 32'h0000_0066);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
